// File: rtl/pp_frame_check.sv
// Frame checker: collects FRAME_LEN bytes, then presents their sum, XOR and
// maximum until the consumer takes them. While a result waits, upstream is backpressured.
module pp_frame_check #(
  parameter int unsigned FRAME_LEN = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        busy,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_sum,
  output logic [7:0]  res_xor,
  output logic [7:0]  res_max,
  output logic [7:0]  frame_cnt,
  input  logic        err_clr,
  output logic        err_overrun
);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  localparam logic [7:0] LEN8 = 8'(FRAME_LEN);

  function automatic logic [7:0] byte_max(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] sum_q, sum_d;
  logic [7:0]  xor_q, xor_d;
  logic [7:0]  max_q, max_d;
  logic [15:0] res_sum_q, res_sum_d;
  logic [7:0]  res_xor_q, res_xor_d;
  logic [7:0]  res_max_q, res_max_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        res_valid_q, res_valid_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic [15:0] sum_nx;
  logic [7:0]  xor_nx, max_nx, cnt_nx;

  assign sum_nx = sum_q + {8'd0, in_data};
  assign xor_nx = xor_q ^ in_data;
  assign max_nx = byte_max(in_data, max_q);
  assign cnt_nx = cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    xor_d       = xor_q;
    max_d       = max_q;
    res_sum_d   = res_sum_q;
    res_xor_d   = res_xor_q;
    res_max_d   = res_max_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sum_d   = {8'd0, in_data};
          xor_d   = in_data;
          max_d   = in_data;
          cnt_d   = 8'd1;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          sum_d = sum_nx;
          xor_d = xor_nx;
          max_d = max_nx;
          cnt_d = cnt_nx;
          if (cnt_nx == LEN8) begin
            res_sum_d   = sum_nx;
            res_xor_d   = xor_nx;
            res_max_d   = max_nx;
            frame_cnt_d = frame_cnt_q + 8'd1;
            cnt_d       = 8'd0;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        // A byte arriving on the handshake cycle opens the next frame.
        if (res_ready) begin
          if (in_valid) begin
            sum_d   = {8'd0, in_data};
            xor_d   = in_data;
            max_d   = in_data;
            cnt_d   = 8'd1;
            state_d = COLLECT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q == HOLD && in_valid && !res_ready) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end

    busy_d      = (state_d == HOLD);
    res_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sum_q       <= '0;
      xor_q       <= '0;
      max_q       <= '0;
      res_sum_q   <= '0;
      res_xor_q   <= '0;
      res_max_q   <= '0;
      frame_cnt_q <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      xor_q       <= xor_d;
      max_q       <= max_d;
      res_sum_q   <= res_sum_d;
      res_xor_q   <= res_xor_d;
      res_max_q   <= res_max_d;
      frame_cnt_q <= frame_cnt_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign busy        = busy_q;
  assign res_valid   = res_valid_q;
  assign res_sum     = res_sum_q;
  assign res_xor     = res_xor_q;
  assign res_max     = res_max_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_overrun = err_q;

endmodule

// File: doc/pp_frame_check.md
PP_FRAME_CHECK -- requirements
Module: pp_frame_check

Interface
REQ-001 Parameter FRAME_LEN, default 64, bytes per frame; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  byte on in_data is valid this cycle (driven by the upstream ping-pong buffer output).
REQ-005 in_data  input  8  stream byte.
REQ-006 busy  output  1  backpressure to the upstream ping-pong buffer; high means bytes will not be accepted.
REQ-007 res_valid  output  1  frame result is available.
REQ-008 res_ready  input  1  consumer accepts the result.
REQ-009 res_sum  output  16  modulo-2^16 sum of the frame bytes.
REQ-010 res_xor  output  8  bitwise XOR of the frame bytes.
REQ-011 res_max  output  8  unsigned maximum of the frame bytes.
REQ-012 frame_cnt  output  8  number of completed frames, wraps 255->0.
REQ-013 err_clr  input  1  synchronous clear of err_overrun.
REQ-014 err_overrun  output  1  sticky flag: a byte arrived while busy and was dropped.

Function
REQ-015 The FSM SHALL have three states: IDLE, COLLECT and HOLD.
REQ-016 A byte SHALL be accepted when in_valid=1 and the state is IDLE or COLLECT, or when the state is HOLD and res_ready=1 in the same cycle.
REQ-017 IDLE with an accepted byte SHALL seed the accumulators with sum=in_data, xor=in_data, max=in_data and byte count=1, then move to COLLECT.
REQ-018 COLLECT SHALL, per accepted byte, add it to sum (16-bit wrap), XOR it into xor, update max if in_data>max, and increment the count.
REQ-019 When the accepted byte makes count equal FRAME_LEN, the block SHALL load res_sum, res_xor and res_max with the final values including that byte, set res_valid on the next edge, increment frame_cnt, and move to HOLD.
REQ-020 Latency SHALL be exactly 1 cycle from the edge that samples the last byte to res_valid=1.
REQ-021 Cycles with in_valid=0 in COLLECT SHALL hold all state; no timeout applies.
REQ-022 HOLD SHALL keep res_valid=1 and res_* stable until res_valid&&res_ready.
REQ-023 On the handshake with in_valid=0, the block SHALL clear res_valid and go to IDLE.
REQ-024 On the handshake with in_valid=1, the block SHALL clear res_valid, accept the byte as byte 1 of the next frame (seeded as in REQ-017), and go to COLLECT.
REQ-025 busy SHALL be registered and equal 1 exactly while the state is HOLD.
REQ-026 in_valid=1 in HOLD without res_ready SHALL drop the byte and set err_overrun.
REQ-027 err_overrun SHALL clear when err_clr=1; if a set condition and err_clr coincide, set wins.
REQ-028 res_* outputs SHALL retain the last frame's values outside HOLD until overwritten by the next frame completion.
REQ-029 res_ready while res_valid=0 SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL immediately force state=IDLE, count=0, accumulators=0, busy=0, res_valid=0, res_sum=0, res_xor=0, res_max=0, frame_cnt=0 and err_overrun=0.
REQ-031 Reset mid-frame SHALL discard the partial frame; the first accepted byte after release starts a new frame.

Verification
REQ-032 Stream bytes 0..63 back-to-back with res_ready=1 -> res_valid high 1 cycle after byte 63, res_sum=0x07E0, res_xor=0x00, res_max=0x3F, frame_cnt=1.
REQ-033 64 bytes of 0xFF with in_valid gaps of 1-3 cycles -> res_sum=0x3FC0, res_xor=0x00, res_max=0xFF; no early res_valid.
REQ-034 Hold res_ready=0 for 10 cycles after completion while driving in_valid=1 -> busy=1, res_* stable, err_overrun=1, dropped bytes absent from the next frame; err_clr=1 -> err_overrun=0.
REQ-035 Raise res_ready together with in_valid=1 and in_data=0x55 in HOLD -> handshake completes, 0x55 becomes byte 1 of the next frame, err_overrun stays 0.
REQ-036 Assert rst_n=0 after 30 bytes, release, then send 64 bytes of 0x01 -> res_sum=0x0040 and frame_cnt=1.
REQ-037 Run 256 frames -> frame_cnt wraps to 0.
